// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU opcode encodings, the
// arbiter FSM state type and the default datapath width.
package alu_arb_pkg;

    localparam int DW_DEFAULT = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting one past last_grant (wrapping), so the previous winner
// has the lowest priority.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  IW       index of the previous winner
//   enable     in  1        when low, no grant is issued
//   grant      out NUM_REQ  one-hot winner (zero if none)
//   grant_idx  out IW       encoded winner index (zero if none)
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    int   cand;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters using round-robin
// arbitration. A granted request is registered onto the ALU inputs, the ALU
// result is captured one cycle later and presented as a response until the
// consumer accepts it.
//
// Optional feature: define ALU_ARB_FLAGS_EN to add resp_zero / resp_neg flag
// outputs captured alongside resp_data.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         per-requester request handshake (ready one-hot)
//   req_a/req_b/req_op/req_operand  flattened per-requester payload
//   alu_a/alu_b/alu_op/alu_operand  registered ALU inputs
//   alu_result                  ALU combinational output
//   resp_valid/resp_ready       response handshake
//   resp_data/resp_id           captured result and owning requester
//   resp_zero/resp_neg          result flags (ALU_ARB_FLAGS_EN only)
//   busy                        high whenever not IDLE
//   ops_done                    completed-response counter, wraps
//
// state | meaning
// IDLE  | arbitrating; req_ready shows the winner, handshake latches payload
// EXEC  | ALU inputs stable; result captured at end of cycle
// RESP  | response presented; waits for resp_ready
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = DW_DEFAULT,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]  req_op,
    input  logic [NUM_REQ-1:0]    req_operand,
    output logic [DW-1:0]         alu_a,
    output logic [DW-1:0]         alu_b,
    output logic [2:0]            alu_op,
    output logic                  alu_operand,
    input  logic [DW-1:0]         alu_result,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DW-1:0]         resp_data,
    output logic [ID_W-1:0]       resp_id,
`ifdef ALU_ARB_FLAGS_EN
    output logic                  resp_zero,
    output logic                  resp_neg,
`endif
    output logic                  busy,
    output logic [15:0]           ops_done
);

    arb_state_t          state;
    logic [ID_W-1:0]     last_grant;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (ID_W)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .enable     (state == IDLE),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // A grant is only issued to a valid requester, so any grant is a handshake.
    assign req_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= ID_W'(NUM_REQ - 1);
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= OP_ADD;
            alu_operand <= 1'b0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_id     <= '0;
            busy        <= 1'b0;
            ops_done    <= 16'd0;
`ifdef ALU_ARB_FLAGS_EN
            resp_zero   <= 1'b0;
            resp_neg    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        alu_a       <= req_a[grant_idx*DW +: DW];
                        alu_b       <= req_b[grant_idx*DW +: DW];
                        alu_op      <= req_op[grant_idx*3 +: 3];
                        alu_operand <= req_operand[grant_idx];
                        resp_id     <= grant_idx;
                        last_grant  <= grant_idx;
                        busy        <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data  <= alu_result;
`ifdef ALU_ARB_FLAGS_EN
                    resp_zero  <= (alu_result == '0);
                    resp_neg   <= alu_result[DW-1];
`endif
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        ops_done   <= ops_done + 16'd1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural ALU attached to
// the alu_* / alu_result ports. A transaction-level model predicts every
// output each cycle; directed scenarios add hand-computed literal checks.
// Optional feature macro: ALU_ARB_FLAGS_EN.
module tb_alu_share_arbiter;
    import alu_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_a;
    logic [N*DW-1:0]   req_b;
    logic [N*3-1:0]    req_op;
    logic [N-1:0]      req_operand;
    logic [DW-1:0]     alu_a;
    logic [DW-1:0]     alu_b;
    logic [2:0]        alu_op;
    logic              alu_operand;
    logic [DW-1:0]     alu_result;
    logic              resp_valid;
    logic              resp_ready;
    logic [DW-1:0]     resp_data;
    logic [IW-1:0]     resp_id;
    logic              busy;
    logic [15:0]       ops_done;
`ifdef ALU_ARB_FLAGS_EN
    logic              resp_zero;
    logic              resp_neg;
`endif

    alu_share_arbiter #(.NUM_REQ(N), .DW(DW), .ID_W(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .req_operand (req_operand),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_operand (alu_operand),
        .alu_result  (alu_result),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_id     (resp_id),
`ifdef ALU_ARB_FLAGS_EN
        .resp_zero   (resp_zero),
        .resp_neg    (resp_neg),
`endif
        .busy        (busy),
        .ops_done    (ops_done)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: operand select 1 picks a, 0 picks b for NOT/SHL/SHR.
    function automatic logic [15:0] alu_f(logic [15:0] a, logic [15:0] b,
                                          logic [2:0] op, logic opd);
        logic [15:0] s;
        s = opd ? a : b;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOT:  return ~s;
            OP_SHL:  return s << 1;
            default: return s >> 1;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op, alu_operand);

    int n_chk  = 0;
    int n_fail = 0;

    // Stimulus: each requester holds its request until the model sees it granted.
    logic        sv   [N];
    logic [15:0] sa   [N];
    logic [15:0] sb   [N];
    logic [2:0]  sop  [N];
    logic        sopd [N];
    logic        s_rr;

    // Transaction-level model: phase 0 waiting, 1 computing, 2 responding.
    int          m_phase;
    int          m_last;
    int          m_id;
    logic [15:0] m_a, m_b, m_data, m_cnt;
    logic [2:0]  m_op;
    logic        m_opd, m_zero, m_neg;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_winner();
        int i;
        if (m_phase != 0) return -1;
        for (int k = 1; k <= N; k++) begin
            i = (m_last + k) % N;
            if (sv[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_last = N - 1; m_id = 0;
        m_a = 0; m_b = 0; m_op = 0; m_opd = 0;
        m_data = 0; m_cnt = 0; m_zero = 0; m_neg = 0;
        for (int i = 0; i < N; i++) begin
            sv[i] = 0; sa[i] = 0; sb[i] = 0; sop[i] = 0; sopd[i] = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = sv[i];
            req_a[i*DW +: DW]     = sa[i];
            req_b[i*DW +: DW]     = sb[i];
            req_op[i*3 +: 3]      = sop[i];
            req_operand[i]        = sopd[i];
        end
        resp_ready = s_rr;
    endtask

    task automatic check_model();
        int w;
        logic [N-1:0] er;
        w  = m_winner();
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        chk("req_ready",   32'(req_ready),   32'(er));
        chk("busy",        32'(busy),        32'(m_phase != 0));
        chk("resp_valid",  32'(resp_valid),  32'(m_phase == 2));
        chk("resp_data",   32'(resp_data),   32'(m_data));
        chk("resp_id",     32'(resp_id),     32'(m_id));
        chk("ops_done",    32'(ops_done),    32'(m_cnt));
        chk("alu_a",       32'(alu_a),       32'(m_a));
        chk("alu_b",       32'(alu_b),       32'(m_b));
        chk("alu_op",      32'(alu_op),      32'(m_op));
        chk("alu_operand", 32'(alu_operand), 32'(m_opd));
`ifdef ALU_ARB_FLAGS_EN
        chk("resp_zero",   32'(resp_zero),   32'(m_zero));
        chk("resp_neg",    32'(resp_neg),    32'(m_neg));
`endif
    endtask

    task automatic model_step();
        int w;
        case (m_phase)
            0: begin
                w = m_winner();
                if (w >= 0) begin
                    m_a = sa[w]; m_b = sb[w]; m_op = sop[w]; m_opd = sopd[w];
                    m_id = w; m_last = w; m_phase = 1;
                    sv[w] = 0;
                end
            end
            1: begin
                m_data  = alu_f(m_a, m_b, m_op, m_opd);
                m_zero  = (m_data == 16'h0);
                m_neg   = m_data[15];
                m_phase = 2;
            end
            default: begin
                if (s_rr) begin
                    m_cnt   = m_cnt + 16'd1;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        check_model();
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        s_rr = 1'b0;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(int n);
        for (int i = 0; i < N; i++) sv[i] = 0;
        s_rr = 1'b1;
        repeat (n) cycle();
    endtask

    task automatic set_req(int i, logic [15:0] a, logic [15:0] b, logic [2:0] op, logic opd);
        sv[i] = 1; sa[i] = a; sb[i] = b; sop[i] = op; sopd[i] = opd;
    endtask

    int ids [$];
    int at  [$];
    int cyc;

    initial begin
        s_rr = 1'b0;
        model_reset();
        drive();
        #1;
        chk("reset_busy",     32'(busy),       32'h0);
        chk("reset_ops_done", 32'(ops_done),   32'h0);
        do_reset();

        // Single requester 1: 5 - 3.
        set_req(1, 16'h0005, 16'h0003, OP_SUB, 1'b0);
        cycle();
        chk("t1_ready_same_cycle", 32'(req_ready), 32'h2);
        cycle();
        chk("t1_no_resp_yet", 32'(resp_valid), 32'h0);
        s_rr = 1'b1;
        cycle();
        chk("t1_resp_valid", 32'(resp_valid), 32'h1);
        chk("t1_resp_data",  32'(resp_data),  32'h0002);
        chk("t1_resp_id",    32'(resp_id),    32'h1);
        cycle();
        chk("t1_ops_done",   32'(ops_done),   32'h1);

        // All four requesting continuously: grants rotate 0,1,2,3,0 every 3 cycles.
        do_reset();
        s_rr = 1'b1;
        cyc = 0;
        repeat (16) begin
            for (int i = 0; i < N; i++)
                if (!sv[i]) set_req(i, 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom));
            cycle();
            for (int i = 0; i < N; i++)
                if (req_ready[i]) begin ids.push_back(i); at.push_back(cyc); end
            cyc++;
        end
        chk("rr_count_ge5", 32'(ids.size() >= 5), 32'h1);
        if (ids.size() >= 5) begin
            chk("rr_seq0", 32'(ids[0]), 32'd0);
            chk("rr_seq1", 32'(ids[1]), 32'd1);
            chk("rr_seq2", 32'(ids[2]), 32'd2);
            chk("rr_seq3", 32'(ids[3]), 32'd3);
            chk("rr_seq4", 32'(ids[4]), 32'd0);
            chk("rr_gap",  32'(at[4] - at[0]), 32'd12);
        end
        drain(4);

        // Requester 0: 0xFFFF + 1 with a stalled consumer.
        set_req(0, 16'hFFFF, 16'h0001, OP_ADD, 1'b0);
        s_rr = 1'b0;
        cycle();
        cycle();
        set_req(2, 16'h1234, 16'h0F0F, OP_AND, 1'b0);
        repeat (5) begin
            cycle();
            chk("t3_hold_data",  32'(resp_data),  32'h0000);
            chk("t3_hold_busy",  32'(busy),       32'h1);
            chk("t3_hold_ready", 32'(req_ready),  32'h0);
            chk("t3_hold_valid", 32'(resp_valid), 32'h1);
        end
        s_rr = 1'b1;
        cycle();
        cycle();
        chk("t3_next_grant", 32'(req_ready), 32'h4);
        drain(5);

        // Shifts and NOT with operand select.
        set_req(2, 16'h7777, 16'h8001, OP_SHR, 1'b0);
        repeat (3) cycle();
        chk("t4_shr", 32'(resp_data), 32'h4000);
`ifdef ALU_ARB_FLAGS_EN
        chk("t4_shr_zero", 32'(resp_zero), 32'h0);
        chk("t4_shr_neg",  32'(resp_neg),  32'h0);
`endif
        set_req(3, 16'h0000, 16'h5A5A, OP_NOT, 1'b1);
        repeat (3) cycle();
        chk("t4_not", 32'(resp_data), 32'hFFFF);
`ifdef ALU_ARB_FLAGS_EN
        chk("t4_not_neg", 32'(resp_neg), 32'h1);
`endif
        drain(3);

        // Async reset while an op is executing.
        set_req(1, 16'h0101, 16'h0202, OP_OR, 1'b0);
        cycle();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        s_rr = 1'b0;
        drive();
        #1;
        chk("t5_busy",       32'(busy),       32'h0);
        chk("t5_resp_valid", 32'(resp_valid), 32'h0);
        chk("t5_alu_a",      32'(alu_a),      32'h0);
        chk("t5_alu_b",      32'(alu_b),      32'h0);
        chk("t5_ops_done",   32'(ops_done),   32'h0);
        chk("t5_resp_id",    32'(resp_id),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 16'h0001, 16'h0001, OP_XOR, 1'b0);
        set_req(3, 16'h0002, 16'h0002, OP_ADD, 1'b0);
        cycle();
        chk("t5_first_grant", 32'(req_ready), 32'h1);
        drain(8);

        // Counter wrap: preload 0xFFFF completions then finish one more op.
        @(negedge clk);
        force dut.ops_done = 16'hFFFF;
        #1;
        release dut.ops_done;
        m_cnt = 16'hFFFF;
        set_req(1, 16'h0003, 16'h0004, OP_ADD, 1'b0);
        s_rr = 1'b1;
        repeat (3) cycle();
        cycle();
        chk("t6_wrap", 32'(ops_done), 32'h0000);
        drain(2);

        // Random traffic.
        repeat (3000) begin
            for (int i = 0; i < N; i++)
                if (!sv[i] && ($urandom_range(0, 2) == 0))
                    set_req(i, 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom));
            s_rr = 1'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
